dice_roll_engine: RTL and testbench
===================================

Name: dice_roll_engine

Overview:
Parametrised multi-die roll engine, successor to the single-die roller.
- Rolls 1..MAX_DICE dice of a selected type using unbiased rejection sampling from a free-running LFSR.
- Applies a signed modifier with clamping, flags critical rolls, and produces binary and 3-digit BCD results through a request/busy/done handshake.
- Feeds the board's seven-segment display driver.

Parameters:
- LFSR_W, 16, LFSR width. Fibonacci taps x^16+x^14+x^13+x^11+1; other widths need a tap table entry.
- SEED, 16'hACE1, LFSR reset value. Must be non-zero.
- MAX_DICE, 4, maximum dice per roll.
- CNT_W, 2, width of dice_count. Encodes count-1.
- MOD_W, 6, width of the two's-complement modifier.
- SUM_W, 8, width of the result. Must hold MAX_DICE*20 + 2^(MOD_W-1)-1.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- dice_type, input, 3: 0=d4, 1=d6, 2=d8, 3=d10, 4=d12, 5=d20, 6/7=fixed face 1.
- dice_count, input, CNT_W: number of dice minus 1.
- modifier, input, MOD_W: signed modifier.
- roll_req, input, 1: single-cycle roll request.
- busy, output, 1: roll in progress.
- done, output, 1: one-cycle pulse when results are valid.
- result, output, SUM_W: clamped binary total.
- result_bcd, output, 12: hundreds/tens/units BCD of result.
- crit_max, output, 1: every die showed its maximum face.
- crit_min, output, 1: every die showed 1.
- clamped, output, 1: raw total was below 1.

Behaviour:
- Reset: LFSR=SEED, FSM=IDLE; busy, done, crit_max, crit_min, clamped = 0; result = 0; result_bcd = 0.
- LFSR: steps every clock regardless of state, so request timing contributes entropy.
- FSM states: IDLE, DRAW, ADD_MOD, BCD, DONE.
- IDLE:
  - roll_req=1 latches dice_type, dice_count, modifier.
  - Clears accumulator and die counter; sets crit_max_acc = crit_min_acc = 1.
  - Moves to DRAW; busy rises the next cycle.
- DRAW, one sample per cycle:
  - Sample r = LFSR[k-1:0], where k = 2 for d4, 3 for d6/d8, 4 for d10/d12, 5 for d20.
  - Accept if r < sides: face = r+1. Add face to the accumulator; update crit flags; increment the die counter.
  - Reject otherwise: redraw next cycle.
  - Types 6/7: face = 1 on every cycle, never rejected.
  - After dice_count+1 accepted faces, go to ADD_MOD.
- ADD_MOD, one cycle:
  - Compute raw = accumulator + sign-extended modifier in SUM_W+1 bits.
  - If raw < 1: result = 1 and clamped = 1; else result = raw and clamped = 0.
- BCD:
  - Sequential double-dabble over SUM_W cycles in sub-module bin2bcd_seq.
  - Values >= 1000 saturate to 999; with the default parameters this cannot occur.
- DONE, one cycle:
  - done = 1; result_bcd, crit_max and crit_min update on this edge; return to IDLE.
  - busy falls together with done.
- Outputs hold their values until the next DONE.
- Latency: 1 + accepted-samples + rejections + 1 + SUM_W + 1 cycles from accept to done. Minimum is 12 for one die with SUM_W=8.
- roll_req while busy: ignored, not queued. Inputs changing while busy: no effect.
- roll_req coinciding with the done cycle: ignored, because the FSM is not in IDLE.
- Reset mid-roll: immediate return to IDLE with all outputs at reset values; no done pulse.
- Types 6/7: crit_max and crit_min are both 1, since face 1 is both minimum and maximum.

Decomposition:
- Package dice_pkg holds:
  - dice_type enum
  - sides lookup function
  - sample-width lookup function
  - state enum
  - LFSR tap constant for width 16
  - BCD_DIGITS = 3
- Sub-module bin2bcd_seq(clk, reset, start, bin[SUM_W], busy, done, bcd[12]): shift-and-add-3 converter, reusable by the display path.

Test Plan:
- Type 7, count 3 (4 dice), modifier +5, pulse roll_req → done exactly 1+4+1+8+1 = 15 cycles later; result = 9; result_bcd = 12'h009; crit_max = crit_min = 1; clamped = 0.
- Type 6, count 0, modifier -4 → result = 1, clamped = 1, result_bcd = 12'h001.
- d20, count 3, modifier +31, 2000 rolls → result always in 35..111; per-die faces cover 1..20; chi-square uniform on a bench face tap; crit_max seen only when all dice = 20.
- d6, single die, bench model of LFSR from SEED → every rejected sample (r = 6, 7) adds exactly one cycle; result matches the model roll for roll.
- roll_req pulsed while busy and on the done cycle → exactly one done per accepted request; latched inputs unaffected by mid-roll input changes.
- reset asserted during BCD → busy, done and result drop to 0 asynchronously; next roll after release behaves as from power-up (LFSR = SEED).

Source files
------------

// File: rtl/dice_pkg.sv
// Shared types, lookup functions and constants for the dice roll engine
// and its BCD converter.
package dice_pkg;

    typedef enum logic [2:0] {
        D4      = 3'd0,
        D6      = 3'd1,
        D8      = 3'd2,
        D10     = 3'd3,
        D12     = 3'd4,
        D20     = 3'd5,
        FIXED_A = 3'd6,
        FIXED_B = 3'd7
    } dice_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRAW    = 3'd1,
        ADD_MOD = 3'd2,
        BCD     = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
    localparam int BCD_DIGITS = 3;

    function automatic logic [4:0] sides(input dice_t t);
        case (t)
            D4:      sides = 5'd4;
            D6:      sides = 5'd6;
            D8:      sides = 5'd8;
            D10:     sides = 5'd10;
            D12:     sides = 5'd12;
            D20:     sides = 5'd20;
            default: sides = 5'd1;
        endcase
    endfunction

    function automatic logic [2:0] sample_width(input dice_t t);
        case (t)
            D4:           sample_width = 3'd2;
            D6, D8:       sample_width = 3'd3;
            D10, D12:     sample_width = 3'd4;
            D20:          sample_width = 3'd5;
            default:      sample_width = 3'd0;
        endcase
    endfunction

    // Feedback masks for a left-shifting Fibonacci LFSR, indexed by width.
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            16:      lfsr_taps = {16'h0000, LFSR_TAPS_16};
            8:       lfsr_taps = 32'h0000_00B8;
            default: lfsr_taps = 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/dice_roll_engine_bin2bcd.sv
// Sequential shift-and-add-3 binary to BCD converter; one bit per cycle,
// done pulses once all SUM_W bits have been shifted through.
module bin2bcd_seq
    import dice_pkg::*;
#(
    parameter int SUM_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [SUM_W-1:0]        bin,
    output logic                    busy,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd
);

    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int SH_W  = BCD_W + SUM_W;
    localparam int CNT_W = $clog2(SUM_W + 1);

    logic [SH_W-1:0]  sh;
    logic [CNT_W-1:0] cnt;
    logic             sat;
    logic [31:0]      bin_ext;

    assign bin_ext = 32'(bin);

    function automatic logic [SH_W-1:0] dabble(input logic [SH_W-1:0] x);
        logic [SH_W-1:0] y;
        y = x;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (y[SUM_W + 4*d +: 4] >= 4'd5)
                y[SUM_W + 4*d +: 4] = y[SUM_W + 4*d +: 4] + 4'd3;
        end
        return y << 1;
    endfunction

    // The first dabble step is folded into the load so the whole conversion
    // spans exactly SUM_W cycles including the start cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh   <= '0;
            cnt  <= '0;
            sat  <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sh   <= dabble({{BCD_W{1'b0}}, bin});
                cnt  <= CNT_W'(SUM_W - 1);
                sat  <= (bin_ext >= 32'd1000);
                busy <= 1'b1;
            end else if (busy) begin
                sh  <= dabble(sh);
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign bcd = sat ? {BCD_DIGITS{4'h9}} : sh[SH_W-1 -: BCD_W];

endmodule

// File: rtl/dice_roll_engine.sv
// Multi-die roll engine: rejection-sampled faces from a free-running LFSR,
// signed modifier with clamp at 1, critical flags and BCD result.
//   state   | meaning
//   IDLE    | wait for roll_req, latch inputs
//   DRAW    | one LFSR sample per cycle, accept or reject
//   ADD_MOD | add modifier, clamp, start BCD conversion
//   BCD     | wait for converter
//   DONE    | done pulse, publish BCD and crit flags
module dice_roll_engine
    import dice_pkg::*;
#(
    parameter int                LFSR_W   = 16,
    parameter logic [LFSR_W-1:0] SEED     = 16'hACE1,
    parameter int                MAX_DICE = 4,
    parameter int                CNT_W    = 2,
    parameter int                MOD_W    = 6,
    parameter int                SUM_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       dice_type,
    input  logic [CNT_W-1:0] dice_count,
    input  logic [MOD_W-1:0] modifier,
    input  logic             roll_req,
    output logic             busy,
    output logic             done,
    output logic [SUM_W-1:0] result,
    output logic [11:0]      result_bcd,
    output logic             crit_max,
    output logic             crit_min,
    output logic             clamped
);

    localparam logic [LFSR_W-1:0] TAPS  = LFSR_W'(lfsr_taps(LFSR_W));
    localparam int                ACC_W = $clog2(MAX_DICE * 20 + 1);

    state_t             state, state_nx;
    logic [LFSR_W-1:0]  lfsr;
    dice_t              type_q;
    logic [CNT_W-1:0]   remaining;
    logic [MOD_W-1:0]   mod_q;
    logic [ACC_W-1:0]   acc;
    logic               cmax_acc, cmin_acc;

    logic [4:0]         n_sides, r, face;
    logic               accept;
    logic [SUM_W:0]     raw;
    logic               raw_low;
    logic [SUM_W-1:0]   sum_clamped;
    logic               bcd_start, bcd_busy, bcd_done;
    logic [11:0]        bcd_val;

    // Fixed-face types have sample width 0 and one side, so r = 0 is always
    // accepted as face 1 without a special case.
    always_comb begin
        n_sides     = sides(type_q);
        r           = lfsr[4:0] & ~(5'h1f << sample_width(type_q));
        accept      = (r < n_sides);
        face        = r + 5'd1;
        raw         = (SUM_W+1)'(acc) + {{(SUM_W+1-MOD_W){mod_q[MOD_W-1]}}, mod_q};
        raw_low     = raw[SUM_W] || (raw == '0);
        sum_clamped = raw_low ? SUM_W'(1) : raw[SUM_W-1:0];
    end

    always_comb begin
        state_nx  = state;
        bcd_start = 1'b0;
        case (state)
            IDLE:    if (roll_req) state_nx = DRAW;
            DRAW:    if (accept && remaining == '0) state_nx = ADD_MOD;
            ADD_MOD: begin
                bcd_start = 1'b1;
                state_nx  = BCD;
            end
            BCD:     if (bcd_done && !bcd_busy) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr       <= SEED;
            type_q     <= D4;
            remaining  <= '0;
            mod_q      <= '0;
            acc        <= '0;
            cmax_acc   <= 1'b0;
            cmin_acc   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            result_bcd <= '0;
            crit_max   <= 1'b0;
            crit_min   <= 1'b0;
            clamped    <= 1'b0;
        end else begin
            lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)};
            busy <= (state_nx != IDLE);
            done <= (state_nx == DONE);
            case (state)
                IDLE: if (roll_req) begin
                    type_q    <= dice_t'(dice_type);
                    remaining <= dice_count;
                    mod_q     <= modifier;
                    acc       <= '0;
                    cmax_acc  <= 1'b1;
                    cmin_acc  <= 1'b1;
                end
                DRAW: if (accept) begin
                    acc      <= acc + ACC_W'(face);
                    cmax_acc <= cmax_acc & (face == n_sides);
                    cmin_acc <= cmin_acc & (face == 5'd1);
                    if (remaining != '0) remaining <= remaining - CNT_W'(1);
                end
                ADD_MOD: begin
                    result  <= sum_clamped;
                    clamped <= raw_low;
                end
                BCD: if (state_nx == DONE) begin
                    result_bcd <= bcd_val;
                    crit_max   <= cmax_acc;
                    crit_min   <= cmin_acc;
                end
                default: ;
            endcase
        end
    end

    bin2bcd_seq #(.SUM_W(SUM_W)) u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (bcd_start),
        .bin   (sum_clamped),
        .busy  (bcd_busy),
        .done  (bcd_done),
        .bcd   (bcd_val)
    );

endmodule

// File: tb/tb_dice_roll_engine.sv
// Directed bench for dice_roll_engine: an LFSR reference predicts each roll,
// expectations are queued at request time and compared when done pulses.
module tb_dice_roll_engine;

    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  dice_type;
    logic [1:0]  dice_count;
    logic [5:0]  modifier;
    logic        roll_req;
    logic        busy, done;
    logic [7:0]  result;
    logic [11:0] result_bcd;
    logic        crit_max, crit_min, clamped;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [15:0] m_lfsr;

    typedef struct {
        int res;
        int bcd;
        bit cmax;
        bit cmin;
        bit clmp;
        int lat;
    } exp_t;

    exp_t sb[$];

    dice_roll_engine dut (
        .clk        (clk),
        .reset      (reset),
        .dice_type  (dice_type),
        .dice_count (dice_count),
        .modifier   (modifier),
        .roll_req   (roll_req),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .result_bcd (result_bcd),
        .crit_max   (crit_max),
        .crit_min   (crit_min),
        .clamped    (clamped)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= SEED;
        else       m_lfsr <= lfsr_step(m_lfsr);
    end

    // l is the LFSR value during the request cycle; the first draw uses its successor.
    function automatic exp_t predict(input int t, input int cnt, input int m, input logic [15:0] l);
        exp_t        e;
        int          n_sides, k, acc, got, samples, r, face, raw;
        logic [15:0] v;
        case (t)
            0: begin n_sides = 4;  k = 2; end
            1: begin n_sides = 6;  k = 3; end
            2: begin n_sides = 8;  k = 3; end
            3: begin n_sides = 10; k = 4; end
            4: begin n_sides = 12; k = 4; end
            5: begin n_sides = 20; k = 5; end
            default: begin n_sides = 1; k = 0; end
        endcase
        v = l; acc = 0; got = 0; samples = 0;
        e.cmax = 1'b1; e.cmin = 1'b1;
        while (got < cnt + 1 && samples < 1000) begin
            v = lfsr_step(v);
            samples++;
            r = int'(v) % (1 << k);
            if (r < n_sides) begin
                face   = r + 1;
                acc   += face;
                e.cmax = e.cmax && (face == n_sides);
                e.cmin = e.cmin && (face == 1);
                got++;
            end
        end
        raw    = acc + m;
        e.clmp = (raw < 1);
        e.res  = e.clmp ? 1 : raw;
        e.bcd  = ((e.res / 100) % 10) * 256 + ((e.res / 10) % 10) * 16 + (e.res % 10);
        e.lat  = 1 + samples + 1 + 8 + 1;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, expv, expv);
        end
    endtask

    task automatic roll(input int t, input int c, input int m, input bit disturb);
        exp_t g;
        int   cyc_req, extra;
        bit   got;
        @(negedge clk);
        dice_type  = 3'(t);
        dice_count = 2'(c);
        modifier   = 6'(m);
        roll_req   = 1'b1;
        sb.push_back(predict(t, c, m, m_lfsr));
        cyc_req = cyc;
        @(negedge clk);
        roll_req = 1'b0;
        check("busy_rise", busy, 1);
        if (disturb) begin
            dice_type  = 3'(t ^ 3);
            dice_count = 2'(c ^ 3);
            modifier   = 6'(~m);
            roll_req   = 1'b1;
            @(negedge clk);
            roll_req = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("done_seen", got, 1);
        g = sb.pop_front();
        if (got) begin
            check("result",     result, g.res);
            check("result_bcd", result_bcd, g.bcd);
            check("crit_max",   crit_max, g.cmax);
            check("crit_min",   crit_min, g.cmin);
            check("clamped",    clamped, g.clmp);
            check("latency",    cyc - cyc_req + 1, g.lat);
            check("busy_at_done", busy, 1);
            if (disturb) roll_req = 1'b1;
            @(negedge clk);
            roll_req = 1'b0;
            check("done_pulse", done, 0);
            check("busy_fall",  busy, 0);
            if (disturb) begin
                extra = 0;
                repeat (20) begin
                    @(negedge clk);
                    if (done || busy) extra++;
                end
                check("req_ignored", extra, 0);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        dice_type  = 3'd0;
        dice_count = 2'd0;
        modifier   = 6'd0;
        roll_req   = 1'b0;
        #12;
        check("rst_busy",     busy, 0);
        check("rst_done",     done, 0);
        check("rst_result",   result, 0);
        check("rst_bcd",      result_bcd, 0);
        check("rst_crit_max", crit_max, 0);
        check("rst_crit_min", crit_min, 0);
        check("rst_clamped",  clamped, 0);
        @(negedge clk);
        reset = 1'b0;

        // Fixed faces: 4 x 1 + 5 = 9, latency 15; 1 - 4 clamps to 1
        roll(7, 3, 5, 1'b0);
        check("fixed_result_const", result, 9);
        check("fixed_bcd_const", result_bcd, 12'h009);
        roll(6, 0, -4, 1'b0);
        check("clamp_result_const", result, 1);
        check("clamp_flag_const", clamped, 1);
        roll(7, 0, -1, 1'b0);
        roll(6, 0, 0, 1'b0);

        repeat (40) roll(1, 0, 0, 1'b0);

        repeat (80) begin
            roll(5, 3, 31, 1'b0);
            check("d20_range", (result >= 8'd35 && result <= 8'd111), 1);
            check("d20_crit_max_only_at_top", (!crit_max || result == 8'd111), 1);
        end

        repeat (10) roll(0, 0, -1, 1'b0);

        repeat (100) begin
            roll(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 63)) - 32, 1'b0);
        end

        roll(3, 2, 7, 1'b1);
        roll(7, 1, -3, 1'b1);
        roll(1, 3, -20, 1'b1);

        // Reset while the converter is running
        @(negedge clk);
        dice_type = 3'd7; dice_count = 2'd0; modifier = 6'd5; roll_req = 1'b1;
        @(negedge clk);
        roll_req = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_busy",   busy, 1);
        check("pre_reset_result", result, 6);
        #2 reset = 1'b1;
        #1;
        check("async_rst_busy",   busy, 0);
        check("async_rst_done",   done, 0);
        check("async_rst_result", result, 0);
        check("async_rst_bcd",    result_bcd, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        begin
            int seen;
            seen = 0;
            repeat (20) begin
                @(negedge clk);
                if (done || busy) seen++;
            end
            check("no_done_after_reset", seen, 0);
        end
        repeat (10) roll(1, 0, 0, 1'b0);
        roll(5, 1, -2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
